// File: rtl/parity_seq_if.sv
// Handshake bus for the bit-serial parity sequencer: word in, parity result out.
interface parity_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_chk;
   logic             in_par;
   logic             out_valid;
   logic             out_ready;
   logic             out_parity;
   logic             out_err;
   logic             busy;

   // Source/consumer side
   modport master (
      output in_valid, in_data, in_chk, in_par, out_ready,
      input  in_ready, out_valid, out_parity, out_err, busy
   );

   // Sequencer side
   modport slave (
      input  in_valid, in_data, in_chk, in_par, out_ready,
      output in_ready, out_valid, out_parity, out_err, busy
   );
endinterface

// File: rtl/parity_seq.sv
// Bit-serial parity sequencer: folds one data bit per cycle through a single
// XOR2 into an accumulator, then holds the parity / check result until taken.
module parity_seq #(
   parameter int unsigned WIDTH = 8,
   parameter bit          ODD   = 1'b0
) (
   input logic         clk,
   input logic         rst_n,
   parity_seq_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shreg;
   logic             acc;
   logic             chk;
   logic             par;
   logic             res_valid;
   logic             res_parity;
   logic             res_err;
   logic             busy;
   logic             fold_c;

   // The one shared XOR2: accumulator folded with the current LSB
   assign fold_c = acc ^ shreg[0];

   // Ready is decoded purely from state, independent of in_valid
   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = res_valid;
   assign bus.out_parity = res_parity;
   assign bus.out_err    = res_err;
   assign bus.busy       = busy;

   // Sequencer FSM with registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         acc        <= 1'b0;
         chk        <= 1'b0;
         par        <= 1'b0;
         res_valid  <= 1'b0;
         res_parity <= 1'b0;
         res_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg <= bus.in_data;
                  acc   <= ODD;
                  chk   <= bus.in_chk;
                  par   <= bus.in_par;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= fold_c;
               shreg <= shreg >> 1;
               cnt   <= cnt + CNT_W'(1);
               // Last bit: publish the result on the same edge the fold completes
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state      <= DONE;
                  res_valid  <= 1'b1;
                  res_parity <= fold_c;
                  res_err    <= chk & (fold_c != par);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state      <= IDLE;
                  res_valid  <= 1'b0;
                  res_parity <= 1'b0;
                  res_err    <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               res_valid  <= 1'b0;
               res_parity <= 1'b0;
               res_err    <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/parity_seq.md
Name: parity_seq

Overview:
- Bit-serial parity sequencer. Takes a WIDTH-bit word over a valid/ready handshake and folds it one bit per cycle through a single 2-input XOR stage with a parity accumulator.
- Returns the even or odd parity bit, or a check result against a supplied parity bit.
- Sits between a word source and a consumer. Replaces a WIDTH-input combinational XOR tree with one shared XOR2 resource.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- ODD, 0, parity sense: 0 = even parity (bit = XOR of all bits); 1 = odd parity (bit = inverted XOR).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  source has a word.
- IN_READY  output  1  block can accept a word.
- IN_DATA  input  WIDTH  word to process; sampled only at acceptance.
- IN_CHK  input  1  1 = check mode, 0 = generate mode; sampled at acceptance.
- IN_PAR  input  1  expected parity bit for check mode; sampled at acceptance.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer takes the result.
- OUT_PARITY  output  1  computed parity bit.
- OUT_ERR  output  1  check mode: computed parity differs from IN_PAR; always 0 in generate mode.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Any unused encoding returns to IDLE on the next edge.
- Reset (RST_N=0, asynchronous): state=IDLE, counter=0, accumulator=0, shift register=0, OUT_VALID=0, OUT_PARITY=0, OUT_ERR=0, BUSY=0. IN_READY=1, because it is decoded from IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the word with no result; the outputs above are forced immediately.
- IN_READY = (state==IDLE). It is combinational from state only and never depends on IN_VALID.
- Acceptance edge (IN_VALID & IN_READY):
  - shift register <= IN_DATA
  - accumulator <= ODD
  - chk/par registers <= IN_CHK/IN_PAR
  - counter <= 0
  - state <= RUN
- RUN, on each edge:
  - accumulator <= accumulator XOR shreg[0]
  - shreg <= shreg >> 1
  - counter <= counter + 1
  - when counter == WIDTH-1 on that edge, state <= DONE.
  - The counter is clog2(WIDTH+1) bits wide and never wraps.
- Latency: acceptance at edge E0. RUN edges are E1..E_WIDTH. OUT_VALID rises after edge E_WIDTH.
- DONE:
  - OUT_VALID=1 and BUSY=1.
  - OUT_PARITY = accumulator.
  - OUT_ERR = chk & (accumulator != par).
  - All outputs are held stable until an edge with OUT_READY=1. On that edge state <= IDLE and OUT_VALID, OUT_PARITY and OUT_ERR clear to 0.
- OUT_PARITY and OUT_ERR are 0 outside DONE.
- IN_VALID asserted in RUN or DONE is ignored: IN_READY=0 and no data is sampled. The source must hold the word until accepted.
- OUT_READY asserted outside DONE has no effect.
- No overlap of result and acceptance. A new word is accepted no earlier than the edge after the DONE→IDLE edge.
- Peak throughput is one word per WIDTH+2 cycles.
- IN_DATA changes after acceptance do not affect the result.

Test Plan:
- Even parity, WIDTH=8, ODD=0: accept 0xB4 with IN_CHK=0, OUT_READY=1.
  - Expected: OUT_VALID rises exactly 8 edges after acceptance, OUT_PARITY=0, OUT_ERR=0.
  - Expected: IN_READY=1 again 9 edges after acceptance.
- Odd count and check mode: accept 0x07 with IN_CHK=0 → OUT_PARITY=1.
  - Then accept 0x07 with IN_CHK=1, IN_PAR=0 → OUT_PARITY=1, OUT_ERR=1.
  - Then accept 0x07 with IN_CHK=1, IN_PAR=1 → OUT_ERR=0.
- ODD=1 build: accept 0xFF → OUT_PARITY=1. Accept 0x01 → OUT_PARITY=0.
- Backpressure: accept 0x5A, hold OUT_READY=0 for 6 cycles after OUT_VALID.
  - Expected: OUT_VALID, OUT_PARITY=0 and BUSY stay constant, and IN_READY=0 throughout.
  - Expected: assert OUT_READY → OUT_VALID=0 and IN_READY=1 after that edge.
- Back-to-back with IN_VALID=1 and OUT_READY=1 continuously, words 0x01, 0x03, 0x80.
  - Expected: acceptances exactly 10 edges apart; OUT_PARITY sequence 1, 0, 1.
  - Expected: IN_DATA changes during RUN do not alter the result.
- Reset mid-operation: pulse RST_N low for less than one cycle, asynchronously, at RUN counter=4.
  - Expected: outputs at reset values immediately, no OUT_VALID for the aborted word.
  - Expected: the next word, 0x0F, gives OUT_PARITY=0 with full 8-edge latency.
